seq_control_unit: RTL and testbench

Parametrised second-generation sequencer for the RISC SPM datapath. It runs the fetch/decode/execute cycle for the NOP/ADD/SUB/AND/NOT/RD/WR/BR/BRZ instruction set, generalised to REG_CNT general registers. Additions over the first generation:
- ready-based memory handshake with arbitrary wait states
- explicit HALT and illegal-opcode trapping, with resume
- a retired-instruction counter

It sits between the instruction register, the register file, the PC and the memory port.

---
 rtl/seq_control_unit.sv | 199 +++++++++++++++++++
 tb/tb_seq_control_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_control_unit.sv
// Fetch/decode/execute sequencer for the RISC SPM datapath with ready-based memory waits, HALT/trap and a retired counter.
// Controls are combinational from state; NOP/NOT 3 cycles, ALU/branch 4, RD/WR 5, plus 1 per mem_ready=0 cycle.
module seq_control_unit #(
    parameter int DATA_W  = 8,
    parameter int REG_CNT = 4,
    parameter int OPC_W   = 4,
    parameter int CNT_W   = 16
) (
    input  logic                             in_clk,
    input  logic                             in_rst,
    input  logic [OPC_W+2*$clog2(REG_CNT)-1:0] instr,
    input  logic                             z_flag_in,
    input  logic                             mem_ready,
    input  logic                             resume,
    output logic [REG_CNT-1:0]               reg_rd_en,
    output logic [REG_CNT-1:0]               reg_wr_en,
    output logic [$clog2(REG_CNT):0]         mux_1_sel,
    output logic [1:0]                       mux_2_sel,
    output logic                             pc_rd_en,
    output logic                             pc_wr_en,
    output logic                             pc_cnt,
    output logic                             ir_wr_en,
    output logic                             reg_y_wr_en,
    output logic                             addr_wr_en,
    output logic                             mem_rd_en,
    output logic                             mem_wr_en,
    output logic                             halted,
    output logic                             illegal_op,
    output logic [CNT_W-1:0]                 retired
);
    localparam int REG_SEL_W = $clog2(REG_CNT);

    localparam logic [OPC_W-1:0] OP_NOP  = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_NOT  = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_RD   = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_WR   = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_BR   = OPC_W'(7);
    localparam logic [OPC_W-1:0] OP_BRZ  = OPC_W'(8);
    localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(9);

    localparam logic [1:0] MUX2_ALU  = 2'd0;
    localparam logic [1:0] MUX2_BUS1 = 2'd1;
    localparam logic [1:0] MUX2_MEM  = 2'd2;
    localparam logic [1:0] MUX2_NONE = 2'd3;
    localparam logic [REG_SEL_W:0] PC_SEL = (REG_SEL_W+1)'(REG_CNT);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH_A, S_FETCH_M, S_DECODE, S_EXEC,
        S_OPND_M, S_DATA_RD, S_DATA_WR, S_HALT
    } state_t;

    state_t state, next_state;

    logic [OPC_W-1:0]     opcode;
    logic [REG_SEL_W-1:0] src;
    logic [REG_SEL_W-1:0] dst;

    assign {opcode, src, dst} = instr;

    // The opcode and both register fields must fit inside one memory word.
    assert property (@(posedge in_clk) (OPC_W + 2*REG_SEL_W) <= DATA_W);

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state      <= S_IDLE;
            retired    <= '0;
            illegal_op <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state == S_FETCH_A && state != S_IDLE && state != S_HALT)
                retired <= retired + CNT_W'(1);
            if (state == S_DECODE && next_state == S_HALT && opcode != OP_HALT)
                illegal_op <= 1'b1;
            else if (state == S_HALT && resume)
                illegal_op <= 1'b0;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    next_state = S_FETCH_A;
            S_FETCH_A: next_state = S_FETCH_M;
            S_FETCH_M: if (mem_ready) next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_NOP, OP_NOT:         next_state = S_FETCH_A;
                    OP_ADD, OP_SUB, OP_AND: next_state = S_EXEC;
                    OP_RD, OP_WR, OP_BR:    next_state = S_OPND_M;
                    OP_BRZ:                 next_state = z_flag_in ? S_OPND_M : S_FETCH_A;
                    default:                next_state = S_HALT;
                endcase
            end
            S_EXEC: next_state = S_FETCH_A;
            S_OPND_M: begin
                if (mem_ready) begin
                    if (opcode == OP_RD)      next_state = S_DATA_RD;
                    else if (opcode == OP_WR) next_state = S_DATA_WR;
                    else                      next_state = S_FETCH_A;
                end
            end
            S_DATA_RD, S_DATA_WR: if (mem_ready) next_state = S_FETCH_A;
            S_HALT:               if (resume) next_state = S_FETCH_A;
            default:              next_state = S_IDLE;
        endcase
    end

    always_comb begin
        reg_rd_en   = '0;
        reg_wr_en   = '0;
        mux_1_sel   = '0;
        mux_2_sel   = MUX2_NONE;
        pc_rd_en    = 1'b0;
        pc_wr_en    = 1'b0;
        pc_cnt      = 1'b0;
        ir_wr_en    = 1'b0;
        reg_y_wr_en = 1'b0;
        addr_wr_en  = 1'b0;
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        halted      = 1'b0;
        case (state)
            S_FETCH_A: begin
                pc_rd_en   = 1'b1;
                mux_1_sel  = PC_SEL;
                mux_2_sel  = MUX2_BUS1;
                addr_wr_en = 1'b1;
            end
            S_FETCH_M: begin
                mem_rd_en = 1'b1;
                mux_2_sel = MUX2_MEM;
                if (mem_ready) begin
                    ir_wr_en = 1'b1;
                    pc_cnt   = 1'b1;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND: begin
                        reg_rd_en[dst] = 1'b1;
                        mux_1_sel      = {1'b0, dst};
                        mux_2_sel      = MUX2_BUS1;
                        reg_y_wr_en    = 1'b1;
                    end
                    OP_NOT: begin
                        reg_rd_en[src] = 1'b1;
                        mux_1_sel      = {1'b0, src};
                        mux_2_sel      = MUX2_ALU;
                        reg_wr_en[dst] = 1'b1;
                    end
                    OP_RD, OP_WR, OP_BR, OP_BRZ: begin
                        if (opcode != OP_BRZ || z_flag_in) begin
                            pc_rd_en   = 1'b1;
                            mux_1_sel  = PC_SEL;
                            mux_2_sel  = MUX2_BUS1;
                            addr_wr_en = 1'b1;
                        end else begin
                            pc_cnt = 1'b1;   // untaken BRZ skips its operand byte
                        end
                    end
                    default: ;
                endcase
            end
            S_EXEC: begin
                reg_rd_en[src] = 1'b1;
                mux_1_sel      = {1'b0, src};
                mux_2_sel      = MUX2_ALU;
                reg_wr_en[dst] = 1'b1;
            end
            S_OPND_M: begin
                mem_rd_en = 1'b1;
                mux_2_sel = MUX2_MEM;
                if (mem_ready) begin
                    if (opcode == OP_RD || opcode == OP_WR) begin
                        addr_wr_en = 1'b1;
                        pc_cnt     = 1'b1;
                    end else begin
                        pc_wr_en = 1'b1;
                    end
                end
            end
            S_DATA_RD: begin
                mem_rd_en = 1'b1;
                mux_2_sel = MUX2_MEM;
                if (mem_ready) reg_wr_en[dst] = 1'b1;
            end
            S_DATA_WR: begin
                reg_rd_en[src] = 1'b1;
                mux_1_sel      = {1'b0, src};
                mem_wr_en      = 1'b1;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_seq_control_unit.sv
module tb_seq_control_unit;
    typedef struct packed {
        logic [3:0] rd;
        logic [3:0] wr;
        logic [2:0] m1;
        logic [1:0] m2;
        logic [9:0] fl;   // {pc_rd,pc_wr,pc_cnt,ir_wr,y_wr,addr_wr,mem_rd,mem_wr,halted,illegal}
    } ctl_t;

    typedef struct {
        logic        rst;
        logic [7:0]  ins;
        logic        z;
        logic        rdy;
        logic        res;
        ctl_t        exp;
        logic [15:0] ret;
    } vec_t;

    localparam logic [9:0] F_PCRD = 10'b1000000000;
    localparam logic [9:0] F_PCWR = 10'b0100000000;
    localparam logic [9:0] F_CNT  = 10'b0010000000;
    localparam logic [9:0] F_IR   = 10'b0001000000;
    localparam logic [9:0] F_Y    = 10'b0000100000;
    localparam logic [9:0] F_ADDR = 10'b0000010000;
    localparam logic [9:0] F_MRD  = 10'b0000001000;
    localparam logic [9:0] F_MWR  = 10'b0000000100;
    localparam logic [9:0] F_HALT = 10'b0000000010;
    localparam logic [9:0] F_ILL  = 10'b0000000001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, z, rdy, res;
    logic [7:0]  ins;
    logic [3:0]  rd_en, wr_en;
    logic [2:0]  m1;
    logic [1:0]  m2;
    logic        pc_rd, pc_wr, pc_cnt, ir_wr, y_wr, addr_wr, mem_rd, mem_wr, halted, illegal;
    logic [15:0] retired;
    ctl_t        act;

    seq_control_unit dut_a (
        .in_clk(clk), .in_rst(rst), .instr(ins), .z_flag_in(z), .mem_ready(rdy), .resume(res),
        .reg_rd_en(rd_en), .reg_wr_en(wr_en), .mux_1_sel(m1), .mux_2_sel(m2),
        .pc_rd_en(pc_rd), .pc_wr_en(pc_wr), .pc_cnt(pc_cnt), .ir_wr_en(ir_wr),
        .reg_y_wr_en(y_wr), .addr_wr_en(addr_wr), .mem_rd_en(mem_rd), .mem_wr_en(mem_wr),
        .halted(halted), .illegal_op(illegal), .retired(retired)
    );

    assign act = {rd_en, wr_en, m1, m2,
                  {pc_rd, pc_wr, pc_cnt, ir_wr, y_wr, addr_wr, mem_rd, mem_wr, halted, illegal}};

    logic        b_rst, b_z, b_rdy, b_res;
    logic [9:0]  b_ins;
    logic [7:0]  b_rd_en, b_wr_en;
    logic [3:0]  b_m1;
    logic [1:0]  b_m2;
    logic        b_pc_rd, b_pc_wr, b_pc_cnt, b_ir_wr, b_y_wr, b_addr_wr, b_mem_rd, b_mem_wr;
    logic        b_halted, b_illegal;
    logic [3:0]  b_retired;

    seq_control_unit #(.DATA_W(16), .REG_CNT(8), .OPC_W(4), .CNT_W(4)) dut_b (
        .in_clk(clk), .in_rst(b_rst), .instr(b_ins), .z_flag_in(b_z), .mem_ready(b_rdy),
        .resume(b_res), .reg_rd_en(b_rd_en), .reg_wr_en(b_wr_en), .mux_1_sel(b_m1),
        .mux_2_sel(b_m2), .pc_rd_en(b_pc_rd), .pc_wr_en(b_pc_wr), .pc_cnt(b_pc_cnt),
        .ir_wr_en(b_ir_wr), .reg_y_wr_en(b_y_wr), .addr_wr_en(b_addr_wr),
        .mem_rd_en(b_mem_rd), .mem_wr_en(b_mem_wr), .halted(b_halted),
        .illegal_op(b_illegal), .retired(b_retired)
    );

    int n_cmp = 0;
    int n_bad = 0;
    vec_t tv[$];
    vec_t sbq[$];
    ctl_t NONE_C, FA_C, FMW_C, FMR_C, OPR_RW_C, OPR_BR_C, HLT_C, HLT_ILL_C;

    function automatic ctl_t c(logic [3:0] r, logic [3:0] w, logic [2:0] s1, logic [1:0] s2,
                               logic [9:0] f);
        ctl_t t;
        t.rd = r; t.wr = w; t.m1 = s1; t.m2 = s2; t.fl = f;
        return t;
    endfunction

    task automatic add(input logic r, input logic [7:0] i, input logic zz, input logic rr,
                       input logic rs, input ctl_t e, input logic [15:0] rt);
        vec_t v;
        v.rst = r; v.ins = i; v.z = zz; v.rdy = rr; v.res = rs; v.exp = e; v.ret = rt;
        tv.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    initial begin
        vec_t v;
        NONE_C    = c(4'h0, 4'h0, 3'd0, 2'd3, 10'd0);
        FA_C      = c(4'h0, 4'h0, 3'd4, 2'd1, F_PCRD | F_ADDR);
        FMW_C     = c(4'h0, 4'h0, 3'd0, 2'd2, F_MRD);
        FMR_C     = c(4'h0, 4'h0, 3'd0, 2'd2, F_MRD | F_IR | F_CNT);
        OPR_RW_C  = c(4'h0, 4'h0, 3'd0, 2'd2, F_MRD | F_ADDR | F_CNT);
        OPR_BR_C  = c(4'h0, 4'h0, 3'd0, 2'd2, F_MRD | F_PCWR);
        HLT_C     = c(4'h0, 4'h0, 3'd0, 2'd3, F_HALT);
        HLT_ILL_C = c(4'h0, 4'h0, 3'd0, 2'd3, F_HALT | F_ILL);

        // ADD src=R2 dst=R1: Y <- R1 in DECODE, R1 <- ALU in EXEC
        add(0, 8'h19, 0, 1, 0, NONE_C, 0);
        add(0, 8'h19, 0, 0, 0, FA_C, 0);
        add(0, 8'h19, 0, 1, 0, FMR_C, 0);
        add(0, 8'h19, 1, 1, 0, c(4'b0010, 4'h0, 3'd1, 2'd1, F_Y), 0);
        add(0, 8'h19, 0, 0, 0, c(4'b0100, 4'b0010, 3'd2, 2'd0, 10'd0), 0);
        // RD into R3 with two wait cycles on each memory access
        add(0, 8'h53, 0, 1, 0, FA_C, 1);
        add(0, 8'h53, 0, 0, 0, FMW_C, 1);
        add(0, 8'h53, 0, 0, 0, FMW_C, 1);
        add(0, 8'h53, 0, 1, 0, FMR_C, 1);
        add(0, 8'h53, 0, 0, 0, FA_C, 1);
        add(0, 8'h53, 0, 0, 0, FMW_C, 1);
        add(0, 8'h53, 0, 0, 0, FMW_C, 1);
        add(0, 8'h53, 0, 1, 0, OPR_RW_C, 1);
        add(0, 8'h53, 0, 0, 0, FMW_C, 1);
        add(0, 8'h53, 0, 0, 0, FMW_C, 1);
        add(0, 8'h53, 0, 1, 0, c(4'h0, 4'b1000, 3'd0, 2'd2, F_MRD), 1);
        // BRZ not taken, then taken
        add(0, 8'h80, 0, 1, 0, FA_C, 2);
        add(0, 8'h80, 0, 1, 0, FMR_C, 2);
        add(0, 8'h80, 0, 1, 0, c(4'h0, 4'h0, 3'd0, 2'd3, F_CNT), 2);
        add(0, 8'h80, 1, 1, 0, FA_C, 3);
        add(0, 8'h80, 1, 1, 0, FMR_C, 3);
        add(0, 8'h80, 1, 0, 0, FA_C, 3);
        add(0, 8'h80, 0, 1, 0, OPR_BR_C, 3);
        // illegal opcode: trap, stay put for 10 cycles, then resume
        add(0, 8'hF0, 0, 1, 0, FA_C, 4);
        add(0, 8'hF0, 0, 1, 0, FMR_C, 4);
        add(0, 8'hF0, 0, 1, 0, NONE_C, 4);
        for (int k = 0; k < 10; k++) add(0, 8'hF0, k[0], 1, 0, HLT_ILL_C, 4);
        add(0, 8'hF0, 0, 1, 1, HLT_ILL_C, 4);
        // WR from R2, resume outside HALT ignored, reset mid-wait
        add(0, 8'h68, 0, 1, 1, FA_C, 4);
        add(0, 8'h68, 0, 1, 0, FMR_C, 4);
        add(0, 8'h68, 0, 1, 0, FA_C, 4);
        add(0, 8'h68, 0, 1, 0, OPR_RW_C, 4);
        add(0, 8'h68, 0, 0, 0, c(4'b0100, 4'h0, 3'd2, 2'd3, F_MWR), 4);
        add(1, 8'h68, 0, 0, 0, c(4'b0100, 4'h0, 3'd2, 2'd3, F_MWR), 4);
        add(0, 8'h68, 0, 1, 0, NONE_C, 0);
        // legal HALT; resume coinciding with reset loses to reset
        add(0, 8'h90, 0, 1, 0, FA_C, 0);
        add(0, 8'h90, 0, 1, 0, FMR_C, 0);
        add(0, 8'h90, 0, 1, 0, NONE_C, 0);
        add(1, 8'h90, 0, 1, 1, HLT_C, 0);
        add(0, 8'h47, 0, 0, 0, NONE_C, 0);
        // NOT R1 -> R3, then NOP
        add(0, 8'h47, 0, 1, 0, FA_C, 0);
        add(0, 8'h47, 0, 1, 0, FMR_C, 0);
        add(0, 8'h47, 0, 1, 0, c(4'b0010, 4'b1000, 3'd1, 2'd0, 10'd0), 0);
        add(0, 8'h00, 0, 1, 0, FA_C, 1);
        add(0, 8'h00, 0, 1, 0, FMR_C, 1);
        add(0, 8'h00, 0, 1, 0, NONE_C, 1);
        add(0, 8'h00, 0, 1, 0, FA_C, 2);

        rst = 1'b1; ins = '0; z = 1'b0; rdy = 1'b0; res = 1'b0;
        b_rst = 1'b1; b_ins = '0; b_z = 1'b0; b_rdy = 1'b0; b_res = 1'b0;
        repeat (3) @(posedge clk);

        for (int i = 0; i < tv.size(); i++) begin
            @(posedge clk); #1;
            rst = tv[i].rst; ins = tv[i].ins; z = tv[i].z; rdy = tv[i].rdy; res = tv[i].res;
            sbq.push_back(tv[i]);
            @(negedge clk);
            v = sbq.pop_front();
            chk($sformatf("vec%0d ctl", i), 32'(act), 32'(v.exp));
            chk($sformatf("vec%0d retired", i), 32'(retired), 32'(v.ret));
        end

        // 8-register build: NOT R5 -> R6, PC select, retired wrap at 4 bits
        @(posedge clk); #1;
        b_rst = 1'b0; b_ins = 10'b0100_101_110; b_rdy = 1'b1;
        @(negedge clk);
        chk("b reset retired", 32'(b_retired), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("b fetch mux_1_sel", 32'(b_m1), 32'd8);
        chk("b fetch pc_rd_en", 32'(b_pc_rd), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("b not reg_rd_en", 32'(b_rd_en), 32'h20);
        chk("b not reg_wr_en", 32'(b_wr_en), 32'h40);
        chk("b not mux_2_sel", 32'(b_m2), 32'd0);
        @(posedge clk); #1;
        b_ins = '0;
        @(negedge clk);
        chk("b retired after not", 32'(b_retired), 32'd1);
        for (int k = 1; k <= 16; k++) begin
            repeat (3) @(posedge clk);
            @(negedge clk);
            chk($sformatf("b retired nop%0d", k), 32'(b_retired), 32'((1 + k) % 16));
            chk($sformatf("b fetch nop%0d", k), 32'(b_pc_rd), 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
